// File: rtl/scr1_dmem_tcm_resp_pkg.sv
// Shared types and defaults for the SCR1 dmem TCM responder.
// Holds the memory-interface enums, window defaults and the alignment helper.
package scr1_dmem_tcm_resp_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;
  localparam int SCR1_TCM_AWIDTH  = 14;
  localparam logic [31:0] SCR1_TCM_BASE = 32'hF000_0000;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    TCM_IDLE   = 2'd0,
    TCM_ACCESS = 2'd1,
    TCM_WAIT   = 2'd2,
    TCM_RESP   = 2'd3
  } tcm_state_e;

  // The reserved width encoding is treated as misaligned so it errors out.
  function automatic logic misaligned(input type_scr1_mem_width_e width,
                                      input logic [1:0] offset);
    logic bad;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  bad = 1'b0;
      SCR1_MEM_WIDTH_HWORD: bad = offset[0];
      SCR1_MEM_WIDTH_WORD:  bad = (offset != 2'b00);
      default:              bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/scr1_dmem_tcm_resp_lane_align.sv
// Byte-lane steering: request-side byte enables and replicated write data,
// response-side right-alignment and zero-extension of the SRAM word.
module scr1_dmem_tcm_resp_lane_align
  import scr1_dmem_tcm_resp_pkg::*;
(
  input  type_scr1_mem_width_e req_width,
  input  logic [1:0]           req_offset,
  input  logic [31:0]          req_wdata,
  output logic [3:0]           be,
  output logic [31:0]          lane_wdata,
  input  type_scr1_mem_width_e rsp_width,
  input  logic [1:0]           rsp_offset,
  input  logic [31:0]          rsp_word,
  output logic [31:0]          rsp_data
);

  logic [31:0] shifted;

  always_comb begin
    be         = 4'h0;
    lane_wdata = req_wdata;
    case (req_width)
      SCR1_MEM_WIDTH_BYTE: begin
        be         = 4'b0001 << req_offset;
        lane_wdata = {4{req_wdata[7:0]}};
      end
      SCR1_MEM_WIDTH_HWORD: begin
        be         = 4'b0011 << req_offset;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      SCR1_MEM_WIDTH_WORD: be = 4'hF;
      default: ;
    endcase
  end

  always_comb begin
    shifted = rsp_word >> {rsp_offset, 3'b000};
    case (rsp_width)
      SCR1_MEM_WIDTH_BYTE:  rsp_data = {24'h0, shifted[7:0]};
      SCR1_MEM_WIDTH_HWORD: rsp_data = {16'h0, shifted[15:0]};
      default:              rsp_data = shifted;
    endcase
  end

endmodule

// File: rtl/scr1_dmem_tcm_resp.sv
// dmem responder for the SCR1 LSU backed by a single-port synchronous TCM.
// Handshake: a request transfers on a cycle with dmem_req & dmem_req_ack; dmem_resp is non-NOTRDY for exactly one cycle per transfer.
module scr1_dmem_tcm_resp
  import scr1_dmem_tcm_resp_pkg::*;
#(
  parameter int          TCM_AWIDTH  = SCR1_TCM_AWIDTH,
  parameter logic [31:0] TCM_BASE    = SCR1_TCM_BASE,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dmem_req,
  input  type_scr1_mem_cmd_e          dmem_cmd,
  input  type_scr1_mem_width_e        dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
  output logic                        dmem_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e         dmem_resp,
  output logic                        sram_ce,
  output logic                        sram_we,
  output logic [3:0]                  sram_be,
  output logic [TCM_AWIDTH-1:0]       sram_addr,
  output logic [31:0]                 sram_wdata,
  input  logic [31:0]                 sram_rdata
);

  // 33-bit bounds so a window at the top of the address space cannot wrap.
  localparam logic [32:0] WIN_LO    = {1'b0, TCM_BASE};
  localparam logic [32:0] WIN_HI    = WIN_LO + (33'd4 << TCM_AWIDTH);
  localparam logic [1:0]  WAIT_LAST = 2'(WAIT_CYCLES - 1);

  tcm_state_e           state;
  logic [1:0]           wait_cnt;
  type_scr1_mem_cmd_e   lat_cmd;
  type_scr1_mem_width_e lat_width;
  logic [1:0]           lat_offset;
  logic                 lat_err;
  logic [31:0]          rd_buf;

  logic        accept;
  logic        in_window;
  logic        req_err;
  logic [3:0]  req_be;
  logic [31:0] req_lane_wdata;
  logic [31:0] rd_word;
  logic [31:0] rd_aligned;

  assign dmem_req_ack = (state == TCM_IDLE) || (state == TCM_RESP);
  assign accept       = dmem_req & dmem_req_ack;
  assign in_window    = ({1'b0, dmem_addr} >= WIN_LO) && ({1'b0, dmem_addr} < WIN_HI);
  assign req_err      = !in_window || misaligned(dmem_width, dmem_addr[1:0]);

  // Without wait states the SRAM word is still valid in RESP and is used directly.
  assign rd_word = (WAIT_CYCLES == 0) ? sram_rdata : rd_buf;

  scr1_dmem_tcm_resp_lane_align u_lane_align (
    .req_width  (dmem_width),
    .req_offset (dmem_addr[1:0]),
    .req_wdata  (dmem_wdata),
    .be         (req_be),
    .lane_wdata (req_lane_wdata),
    .rsp_width  (lat_width),
    .rsp_offset (lat_offset),
    .rsp_word   (rd_word),
    .rsp_data   (rd_aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= TCM_IDLE;
      wait_cnt   <= 2'd0;
      lat_cmd    <= SCR1_MEM_CMD_RD;
      lat_width  <= SCR1_MEM_WIDTH_BYTE;
      lat_offset <= 2'd0;
      lat_err    <= 1'b0;
      rd_buf     <= 32'h0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_be    <= 4'h0;
      sram_addr  <= '0;
      sram_wdata <= 32'h0;
    end else begin
      sram_ce <= 1'b0;
      if (accept) begin
        lat_cmd    <= dmem_cmd;
        lat_width  <= dmem_width;
        lat_offset <= dmem_addr[1:0];
        lat_err    <= req_err;
        if (req_err) begin
          state <= TCM_RESP;
        end else begin
          state      <= TCM_ACCESS;
          sram_ce    <= 1'b1;
          sram_we    <= (dmem_cmd == SCR1_MEM_CMD_WR);
          sram_be    <= req_be;
          sram_addr  <= dmem_addr[TCM_AWIDTH+1:2];
          sram_wdata <= req_lane_wdata;
        end
      end else begin
        case (state)
          TCM_IDLE: state <= TCM_IDLE;
          TCM_ACCESS: begin
            if (WAIT_CYCLES > 0) begin
              state    <= TCM_WAIT;
              wait_cnt <= WAIT_LAST;
            end else begin
              state <= TCM_RESP;
            end
          end
          TCM_WAIT: begin
            // First WAIT cycle is the only one where the SRAM word is valid.
            if (wait_cnt == WAIT_LAST) rd_buf <= sram_rdata;
            if (wait_cnt == 2'd0) state <= TCM_RESP;
            else                  wait_cnt <= wait_cnt - 2'd1;
          end
          default: state <= TCM_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata = '0;
    if (state == TCM_RESP) begin
      if (lat_err) begin
        dmem_resp = SCR1_MEM_RESP_RDY_ER;
      end else begin
        dmem_resp = SCR1_MEM_RESP_RDY_OK;
        if (lat_cmd == SCR1_MEM_CMD_RD) dmem_rdata = rd_aligned;
      end
    end
  end

endmodule
